// File: rtl/dma_mc_pkg.sv
// Shared register map, control-bit positions and engine state encoding for the
// multi-channel DMA controller.
package dma_mc_pkg;

    localparam int unsigned CH_STRIDE     = 'h10;
    localparam int unsigned OFF_CTRL      = 'h0;
    localparam int unsigned OFF_SRC       = 'h4;
    localparam int unsigned OFF_DST       = 'h8;
    localparam int unsigned OFF_LEN       = 'hC;
    localparam int unsigned OFF_INTR_STAT = 'h0;
    localparam int unsigned OFF_BUSY_STAT = 'h4;

    localparam int unsigned CTRL_EN = 0;
    localparam int unsigned CTRL_IE = 1;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        UPDATE,
        DONE
    } state_t;

endpackage

// File: rtl/dma_rr_arb.sv
// Round-robin arbiter: searches from the channel after the last one served and
// moves its priority pointer only when the engine commits to a grant.
module dma_rr_arb #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [NUM_CH-1:0] gnt,
    output logic [IDX_W-1:0]  idx
);

    logic [IDX_W-1:0] ptr_q;
    int unsigned      pos;
    logic             found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            pos = 32'(ptr_q) + i;
            if (pos >= NUM_CH) begin
                pos = pos - NUM_CH;
            end
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = IDX_W'(pos);
            end
        end
    end

    // Pointer starts at the last channel so channel 0 wins the first round.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= IDX_W'(NUM_CH - 1);
        end else if (advance && found) begin
            ptr_q <= idx;
        end
    end

endmodule

// File: rtl/dma_mc.sv
// Multi-channel DMA controller: per-channel register slave plus a single transfer
// engine that copies one word per arbitration round over a req/gnt memory port.
module dma_mc
    import dma_mc_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           NUM_CH     = 4,
    parameter int unsigned           LEN_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h400
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  wr_en,
    input  logic                  valid,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_gnt,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid,
    output logic [NUM_CH-1:0]     busy,
    output logic                  irq
);

    localparam int unsigned           IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] GLOB_BASE = BASE_ADDR + ADDR_WIDTH'(NUM_CH * CH_STRIDE);

    logic [NUM_CH-1:0]     en_q, ie_q, intr_q;
    logic [ADDR_WIDTH-1:0] src_q [NUM_CH];
    logic [ADDR_WIDTH-1:0] dst_q [NUM_CH];
    logic [LEN_WIDTH-1:0]  len_q [NUM_CH];

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      cur_q;
    logic [NUM_CH-1:0]     cur_oh_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  arb_adv;
    logic [NUM_CH-1:0]     arb_gnt;
    logic [IDX_W-1:0]      arb_idx;

    logic                  wr_acc, rd_acc;
    logic [ADDR_WIDTH-1:0] ch_base;
    logic [NUM_CH-1:0]     wr_ctrl, wr_src, wr_dst, wr_len;
    logic                  wr_intr;
    logic [DATA_WIDTH-1:0] rd_val;
    logic [NUM_CH-1:0]     upd_hit, done_hit;

    assign wr_acc    = valid & wr_en;
    assign rd_acc    = valid & ~wr_en;
    assign rdata     = rdata_q;
    assign busy      = en_q;
    assign irq       = |(intr_q & ie_q);
    assign mem_wdata = data_q;
    assign upd_hit   = (state_q == UPDATE) ? cur_oh_q : '0;
    assign done_hit  = (state_q == DONE) ? (cur_oh_q & en_q) : '0;

    always_comb begin
        wr_ctrl = '0;
        wr_src  = '0;
        wr_dst  = '0;
        wr_len  = '0;
        wr_intr = 1'b0;
        rd_val  = '0;
        ch_base = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_base = BASE_ADDR + ADDR_WIDTH'(c * CH_STRIDE);
            if (addr == ch_base + ADDR_WIDTH'(OFF_CTRL)) begin
                wr_ctrl[c] = wr_acc;
                rd_val     = DATA_WIDTH'({ie_q[c], en_q[c]});
            end
            if (addr == ch_base + ADDR_WIDTH'(OFF_SRC)) begin
                wr_src[c] = wr_acc;
                rd_val    = DATA_WIDTH'(src_q[c]);
            end
            if (addr == ch_base + ADDR_WIDTH'(OFF_DST)) begin
                wr_dst[c] = wr_acc;
                rd_val    = DATA_WIDTH'(dst_q[c]);
            end
            if (addr == ch_base + ADDR_WIDTH'(OFF_LEN)) begin
                wr_len[c] = wr_acc;
                rd_val    = DATA_WIDTH'(len_q[c]);
            end
        end
        if (addr == GLOB_BASE + ADDR_WIDTH'(OFF_INTR_STAT)) begin
            wr_intr = wr_acc;
            rd_val  = DATA_WIDTH'(intr_q);
        end
        if (addr == GLOB_BASE + ADDR_WIDTH'(OFF_BUSY_STAT)) begin
            rd_val = DATA_WIDTH'(en_q);
        end
    end

    // Later assignments win: software writes land only on idle channels, and
    // hardware completion overrides both the EN write and the W1C.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q   <= '0;
            ie_q   <= '0;
            intr_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                src_q[c] <= '0;
                dst_q[c] <= '0;
                len_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (upd_hit[c]) begin
                    src_q[c] <= src_q[c] + STEP;
                    dst_q[c] <= dst_q[c] + STEP;
                    len_q[c] <= len_q[c] - LEN_WIDTH'(1);
                end
                if (!en_q[c]) begin
                    if (wr_src[c]) src_q[c] <= ADDR_WIDTH'(wdata);
                    if (wr_dst[c]) dst_q[c] <= ADDR_WIDTH'(wdata);
                    if (wr_len[c]) len_q[c] <= LEN_WIDTH'(wdata);
                end
                if (wr_ctrl[c]) begin
                    en_q[c] <= wdata[CTRL_EN];
                    ie_q[c] <= wdata[CTRL_IE];
                end
                if (wr_intr && wdata[c]) intr_q[c] <= 1'b0;
                if (done_hit[c]) begin
                    en_q[c]   <= 1'b0;
                    intr_q[c] <= 1'b1;
                end
            end
        end
    end

    dma_rr_arb #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (en_q),
        .advance (arb_adv),
        .gnt     (arb_gnt),
        .idx     (arb_idx)
    );

    always_comb begin
        state_d  = state_q;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = src_q[cur_q];
        arb_adv  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|en_q) state_d = ARB;
            end
            ARB: begin
                if (|en_q) begin
                    arb_adv = 1'b1;
                    state_d = (len_q[arb_idx] == '0) ? DONE : RD_REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_REQ: begin
                mem_req = 1'b1;
                if (mem_gnt) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (mem_rvalid) state_d = WR_REQ;
            end
            WR_REQ: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = dst_q[cur_q];
                if (mem_gnt) state_d = UPDATE;
            end
            UPDATE: begin
                // An aborted channel (EN already cleared) skips DONE entirely.
                if (en_q[cur_q] && len_q[cur_q] == LEN_WIDTH'(1)) state_d = DONE;
                else                                              state_d = ARB;
            end
            DONE: begin
                state_d = (|(en_q & ~cur_oh_q)) ? ARB : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cur_q    <= '0;
            cur_oh_q <= '0;
            data_q   <= '0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (arb_adv) begin
                cur_q    <= arb_idx;
                cur_oh_q <= arb_gnt;
            end
            if (state_q == RD_WAIT && mem_rvalid) data_q <= mem_rdata;
            if (rd_acc) rdata_q <= rd_val;
        end
    end

endmodule

// File: tb/tb_dma_mc.sv
// Directed bench for dma_mc: a zero-wait memory model (optional grant stall)
// logs every accepted access; each step checks against hand-computed values.
module tb_dma_mc;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0;
    logic        wr_en = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt;
    logic [31:0] mem_rdata = '0;
    logic        mem_rvalid = 1'b0;
    logic [3:0]  busy;
    logic        irq;

    logic        stall = 1'b0;
    logic [31:0] wr_a[$];
    logic [31:0] wr_d[$];
    logic [31:0] rd_a[$];
    int          req_cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    dma_mc #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_CH     (4),
        .LEN_WIDTH  (16),
        .BASE_ADDR  (32'h400)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .wr_en      (wr_en),
        .valid      (valid),
        .wdata      (wdata),
        .rdata      (rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .busy       (busy),
        .irq        (irq)
    );

    // Memory returns addr ^ 0x5A5A0000 one cycle after an accepted read.
    assign mem_gnt = mem_req & ~stall;

    always @(posedge clk) begin
        mem_rvalid <= mem_req && mem_gnt && !mem_we;
        mem_rdata  <= mem_addr ^ 32'h5A5A_0000;
        if (mem_req && mem_gnt && mem_we) begin
            wr_a.push_back(mem_addr);
            wr_d.push_back(mem_wdata);
        end
        if (mem_req && mem_gnt && !mem_we) rd_a.push_back(mem_addr);
        if (mem_req) req_cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reg_wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic reg_rd(input logic [31:0] a, output logic [31:0] d);
        addr  = a;
        wr_en = 1'b0;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        d     = rdata;
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int k = 0;
        while (busy !== 4'h0 && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(busy), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int wb, rb, r0, k;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_rdata", rdata, 32'h0);

        // 1: single channel, three words
        wb = wr_a.size(); rb = rd_a.size();
        reg_wr(32'h404, 32'h1000);
        reg_wr(32'h408, 32'h2000);
        reg_wr(32'h40C, 32'd3);
        reg_wr(32'h400, 32'h3);
        wait_idle("t1_idle", 100);
        check("t1_nwr", 32'(wr_a.size() - wb), 32'd3);
        check("t1_rd0", rd_a[rb], 32'h1000);
        check("t1_rd1", rd_a[rb+1], 32'h1004);
        check("t1_rd2", rd_a[rb+2], 32'h1008);
        check("t1_wa0", wr_a[wb], 32'h2000);
        check("t1_wa1", wr_a[wb+1], 32'h2004);
        check("t1_wa2", wr_a[wb+2], 32'h2008);
        check("t1_wd0", wr_d[wb], 32'h5A5A1000);
        check("t1_wd1", wr_d[wb+1], 32'h5A5A1004);
        check("t1_wd2", wr_d[wb+2], 32'h5A5A1008);
        check("t1_irq", 32'(irq), 32'h1);
        reg_rd(32'h440, d); check("t1_intr", d, 32'h1);
        reg_rd(32'h400, d); check("t1_ctrl", d, 32'h2);
        reg_rd(32'h404, d); check("t1_src", d, 32'h100C);
        reg_wr(32'h440, 32'h1);
        check("t1_irq_clr", 32'(irq), 32'h0);

        // 3: zero-length start on ch1
        r0 = req_cyc;
        reg_wr(32'h410, 32'h3);
        k = 0;
        while (!irq && k < 3) begin
            @(negedge clk);
            k++;
        end
        check("t3_irq", 32'(irq), 32'h1);
        wait_idle("t3_idle", 10);
        check("t3_no_req", 32'(req_cyc - r0), 32'h0);
        reg_rd(32'h440, d); check("t3_intr", d, 32'h2);
        reg_wr(32'h440, 32'h2);

        // Reset re-homes the arbiter pointer so ch0 is served first below.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // 2: ch0 and ch2 interleaved
        wb = wr_a.size();
        reg_wr(32'h404, 32'h3000);
        reg_wr(32'h408, 32'h4000);
        reg_wr(32'h40C, 32'd2);
        reg_wr(32'h424, 32'h5000);
        reg_wr(32'h428, 32'h6000);
        reg_wr(32'h42C, 32'd2);
        reg_wr(32'h400, 32'h3);
        reg_wr(32'h420, 32'h3);
        wait_idle("t2_idle", 200);
        check("t2_nwr", 32'(wr_a.size() - wb), 32'd4);
        check("t2_wa0", wr_a[wb], 32'h4000);
        check("t2_wa1", wr_a[wb+1], 32'h6000);
        check("t2_wa2", wr_a[wb+2], 32'h4004);
        check("t2_wa3", wr_a[wb+3], 32'h6004);
        check("t2_wd0", wr_d[wb], 32'h5A5A3000);
        check("t2_wd1", wr_d[wb+1], 32'h5A5A5000);
        check("t2_wd2", wr_d[wb+2], 32'h5A5A3004);
        check("t2_wd3", wr_d[wb+3], 32'h5A5A5004);
        check("t2_irq", 32'(irq), 32'h1);
        reg_rd(32'h440, d); check("t2_intr", d, 32'h5);
        reg_rd(32'h444, d); check("t2_busy_stat", d, 32'h0);
        reg_wr(32'h440, 32'h5);

        // 4: grant stall and source address wrap on ch3
        wb = wr_a.size(); rb = rd_a.size();
        stall = 1'b1;
        reg_wr(32'h434, 32'hFFFF_FFFC);
        reg_wr(32'h438, 32'h7000);
        reg_wr(32'h43C, 32'd2);
        reg_wr(32'h430, 32'h3);
        k = 0;
        while (!mem_req && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t4_req", 32'(mem_req), 32'h1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t4_hold_addr%0d", i), mem_addr, 32'hFFFF_FFFC);
            check($sformatf("t4_hold_we%0d", i), 32'(mem_we), 32'h0);
            @(negedge clk);
        end
        stall = 1'b0;
        wait_idle("t4_idle", 100);
        check("t4_rd0", rd_a[rb], 32'hFFFF_FFFC);
        check("t4_rd1", rd_a[rb+1], 32'h0000_0000);
        check("t4_wa1", wr_a[wb+1], 32'h7004);
        check("t4_wd0", wr_d[wb], 32'hA5A5_FFFC);
        check("t4_wd1", wr_d[wb+1], 32'h5A5A_0000);
        reg_wr(32'h440, 32'h8);

        // 5: abort ch0 after three words; SRC write while busy is dropped
        wb = wr_a.size();
        reg_wr(32'h404, 32'h8000);
        reg_wr(32'h408, 32'h9000);
        reg_wr(32'h40C, 32'd10);
        reg_wr(32'h400, 32'h3);
        reg_wr(32'h404, 32'hDEAD_0000);
        reg_rd(32'h404, d); check("t5_src_locked", d, 32'h8000);
        k = 0;
        while ((wr_a.size() - wb) < 3 && k < 100) begin
            @(negedge clk);
            k++;
        end
        reg_wr(32'h400, 32'h2);
        repeat (20) @(negedge clk);
        check("t5_busy", 32'(busy), 32'h0);
        check("t5_nwr_3or4", 32'((wr_a.size() - wb) == 3 || (wr_a.size() - wb) == 4), 32'h1);
        reg_rd(32'h440, d); check("t5_intr", d, 32'h0);
        check("t5_irq", 32'(irq), 32'h0);

        // 6: reset mid write request
        reg_wr(32'h414, 32'hA000);
        reg_wr(32'h418, 32'hB000);
        reg_wr(32'h41C, 32'd4);
        reg_wr(32'h410, 32'h3);
        k = 0;
        while (!(mem_req && mem_we) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("t6_in_wr", 32'(mem_req && mem_we), 32'h1);
        reset = 1'b1;
        #1;
        check("t6_req_async", 32'(mem_req), 32'h0);
        check("t6_busy_async", 32'(busy), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        check("t6_rdata", rdata, 32'h0);
        reg_rd(32'h410, d); check("t6_ctrl", d, 32'h0);
        reg_rd(32'h414, d); check("t6_src", d, 32'h0);
        reg_rd(32'h418, d); check("t6_dst", d, 32'h0);
        reg_rd(32'h41C, d); check("t6_len", d, 32'h0);
        reg_rd(32'h440, d); check("t6_intr", d, 32'h0);
        reg_rd(32'h444, d); check("t6_busy_stat", d, 32'h0);
        reg_wr(32'h404, 32'h1234);
        reg_rd(32'h500, d); check("t6_unmapped", d, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
